facc_ieee754: RTL and testbench
===============================

// Module: facc_ieee754
// PURPOSE
//  Sequential IEEE-754 single-precision accumulator; sits directly downstream of the FP multiplier.
//  Sums a stream of products into a running total; emits the sum when the term flagged last completes.
//  Numeric model matches the multiplier: denormal inputs and zero exponent read as zero; no NaN handling.
//  Overflow produces signed infinity.
// PARAMETERS
//  CNT_W  16  width of the accepted-term counter out_count; saturates at all-ones
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  clear      in   1      synchronous abort and zero of accumulator/counter
//  in_valid   in   1      in_data/in_last valid
//  in_ready   out  1      block can accept a term
//  in_data    in   32     IEEE-754 single term (product)
//  in_last    in   1      term is final of current sum
//  out_valid  out  1      out_sum/out_count/out_ovf valid
//  out_ready  in   1      consumer takes result
//  out_sum    out  32     accumulated IEEE-754 sum
//  out_count  out  CNT_W  number of terms in out_sum
//  out_ovf    out  1      exponent overflow occurred in this sum (sticky per sum)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, acc=+0, count=0, in_ready=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
//  FSM IDLE->ALIGN->ADD->NORM->(IDLE | DONE); one state per cycle.
//  IDLE: in_ready=1 (when clear=0). Transfer on in_valid&in_ready; latch term, last flag; count+=1 (saturating).
//  ALIGN: unpack term and acc to 24b mantissa + 3 ext bits (G,R,S); larger-exponent operand kept.
//   Smaller one shifted right by exponent difference; shifted-out bits OR into S; diff>=27 -> S only.
//  ADD: equal signs add, else subtract smaller magnitude from larger; result sign = larger operand's.
//   Exact zero result -> +0.
//  NORM: carry-out -> shift right 1, exp+1; else leading-zero count, shift left, exp-=lzc.
//   exp<=0 -> flush to +0. exp>=255 -> {sign,8'hFF,23'b0}, out_ovf sticky set.
//   Inf acc stays Inf for rest of sum. Write acc; last ? DONE : IDLE.
//  Fixed latency: term accepted at cycle T -> acc updated end of T+3; in_ready again at T+4 (1 term/4 clk).
//  DONE: out_valid=1, out_sum=acc, out_count=count, out_ovf held stable until out_valid&out_ready.
//   On transfer: acc=+0, count=0, ovf=0, ->IDLE.
//  Backpressure: out_ready=0 holds DONE indefinitely; in_ready=0 outside IDLE.
//  clear=1 (any state): next cycle state=IDLE, acc=+0, count=0, ovf=0, out_valid=0.
//   in_ready forced 0 while clear=1. clear beats both handshakes in the same cycle.
//  Rounding applied in NORM per CONFIGURATION; rounding carry renormalises (mantissa overflow -> exp+1).
// CONFIGURATION
//  FACC_RNE_ROUND_EN defined: round-to-nearest-even from G,R,S after normalisation.
//  FACC_RNE_ROUND_EN undefined: truncate (G,R,S discarded), matching the multiplier's truncation.
// TESTING
//  3F800000, then 40000000 last -> out_sum=40400000, out_count=2, out_ovf=0.
//  3F800000, then BF800000 last -> out_sum=00000000 (+0), out_count=2.
//  3F800000, then denormal 00000001 last -> out_sum=3F800000.
//  7F7FFFFF, then 7F7FFFFF last -> out_sum=7F800000, out_ovf=1.
//  3F800000, then 33C00000 last -> truncate: 3F800000; FACC_RNE_ROUND_EN: 3F800001.
//  out_ready=0 5 cycles in DONE -> out_* stable, in_ready=0.
//   clear pulse during ALIGN -> IDLE next clk, next result counts only new terms.
//   rst_n low mid-sum -> all outputs 0 immediately.

Source files
------------

// File: rtl/facc_ieee754.sv
// rtl/facc_ieee754.sv - sequential IEEE-754 single-precision accumulator, one term per 4 clocks.
// FACC_RNE_ROUND_EN selects round-to-nearest-even; otherwise results are truncated.
module facc_ieee754 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  state_t           r_state, w_next;
  logic             r_live;
  logic [31:0]      r_acc, r_term;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf, r_last;
  logic             r_big_sign, r_eff_sub;
  logic [7:0]       r_big_exp;
  logic [26:0]      r_big_man, r_sml_man;
  logic             r_sum_sign;
  logic [7:0]       r_sum_exp;
  logic [27:0]      r_sum;

  logic [30:0] w_t_key, w_a_key, w_big_key, w_sml_key;
  logic        w_term_big, w_big_sign, w_sml_sign;
  logic [7:0]  w_big_exp, w_sml_exp, w_diff;
  logic [26:0] w_big_man, w_sml_man, w_mask, w_sml_sh;
  logic [27:0] w_sum;
  logic [4:0]  w_lzc;
  logic [26:0] w_nman;
  logic signed [9:0] w_nexp, w_rexp;
  logic        w_rnd_up;
  logic [24:0] w_mant25;
  logic [22:0] w_frac;
  logic [31:0] w_res;
  logic        w_res_ovf;

  // Alignment: denormals read as zero, so a zero exponent collapses the whole key.
  always_comb begin
    w_t_key    = (r_term[30:23] == 8'd0) ? 31'd0 : r_term[30:0];
    w_a_key    = (r_acc[30:23] == 8'd0) ? 31'd0 : r_acc[30:0];
    w_term_big = w_t_key > w_a_key;
    w_big_key  = w_term_big ? w_t_key : w_a_key;
    w_sml_key  = w_term_big ? w_a_key : w_t_key;
    w_big_sign = w_term_big ? r_term[31] : r_acc[31];
    w_sml_sign = w_term_big ? r_acc[31] : r_term[31];
    w_big_exp  = w_big_key[30:23];
    w_sml_exp  = w_sml_key[30:23];
    w_big_man  = (w_big_exp == 8'd0) ? 27'd0 : {1'b1, w_big_key[22:0], 3'b000};
    w_sml_man  = (w_sml_exp == 8'd0) ? 27'd0 : {1'b1, w_sml_key[22:0], 3'b000};
    w_diff     = w_big_exp - w_sml_exp;
    w_mask     = (27'd1 << w_diff) - 27'd1;
    if (w_diff >= 8'd27) begin
      w_sml_sh = {26'd0, |w_sml_man};
    end else begin
      w_sml_sh = (w_sml_man >> w_diff) | {26'd0, |(w_sml_man & w_mask)};
    end
  end

  always_comb begin
    if (r_eff_sub) begin
      w_sum = {1'b0, r_big_man} - {1'b0, r_sml_man};
    end else begin
      w_sum = {1'b0, r_big_man} + {1'b0, r_sml_man};
    end
  end

  always_comb begin
    w_lzc = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (r_sum[i]) w_lzc = 5'(26 - i);
    end
    if (r_sum[27]) begin
      w_nman = {r_sum[27:2], r_sum[1] | r_sum[0]};
      w_nexp = $signed({2'b00, r_sum_exp}) + 10'sd1;
    end else begin
      w_nman = r_sum[26:0] << w_lzc;
      w_nexp = $signed({2'b00, r_sum_exp}) - $signed({5'd0, w_lzc});
    end
`ifdef FACC_RNE_ROUND_EN
    w_rnd_up = w_nman[2] & (w_nman[1] | w_nman[0] | w_nman[3]);
`else
    w_rnd_up = 1'b0;
`endif
    w_mant25 = {1'b0, w_nman[26:3]} + {24'd0, w_rnd_up};
    if (w_mant25[24]) begin
      w_frac = w_mant25[23:1];
      w_rexp = w_nexp + 10'sd1;
    end else begin
      w_frac = w_mant25[22:0];
      w_rexp = w_nexp;
    end
    w_res     = 32'd0;
    w_res_ovf = 1'b0;
    if (w_nman == 27'd0 || w_rexp <= 10'sd0) begin
      w_res = 32'd0;
    end else if (w_rexp >= 10'sd255) begin
      w_res     = {r_sum_sign, 8'hFF, 23'd0};
      w_res_ovf = 1'b1;
    end else begin
      w_res = {r_sum_sign, w_rexp[7:0], w_frac};
    end
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid && r_live) w_next = S_ALIGN;
        S_ALIGN: w_next = S_ADD;
        S_ADD:   w_next = S_NORM;
        S_NORM:  w_next = r_last ? S_DONE : S_IDLE;
        S_DONE:  if (out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= 32'd0;
      r_term     <= 32'd0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_last     <= 1'b0;
      r_big_sign <= 1'b0;
      r_eff_sub  <= 1'b0;
      r_big_exp  <= 8'd0;
      r_big_man  <= 27'd0;
      r_sml_man  <= 27'd0;
      r_sum_sign <= 1'b0;
      r_sum_exp  <= 8'd0;
      r_sum      <= 28'd0;
    end else if (clear) begin
      r_acc   <= 32'd0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_live) begin
            r_term <= in_data;
            r_last <= in_last;
            if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
          end
        end
        S_ALIGN: begin
          r_big_sign <= w_big_sign;
          r_eff_sub  <= w_big_sign ^ w_sml_sign;
          r_big_exp  <= w_big_exp;
          r_big_man  <= w_big_man;
          r_sml_man  <= w_sml_sh;
        end
        S_ADD: begin
          r_sum      <= w_sum;
          r_sum_exp  <= r_big_exp;
          r_sum_sign <= r_big_sign & (w_sum != 28'd0);
        end
        S_NORM: begin
          // An infinite accumulator is frozen until the sum is delivered or cleared.
          if (r_acc[30:23] != 8'hFF) begin
            r_acc <= w_res;
            r_ovf <= r_ovf | w_res_ovf;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_acc   <= 32'd0;
            r_count <= '0;
            r_ovf   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !clear && r_live;
  assign out_valid = (r_state == S_DONE);
  assign out_sum   = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_facc_ieee754.sv
// tb/tb_facc_ieee754.sv - bench for facc_ieee754 against an exact-arithmetic float model.
// FACC_RNE_ROUND_EN selects the rounding mode of the model as well.
module tb_facc_ieee754;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n, clear, in_valid, in_ready, in_last;
  logic             out_valid, out_ready, out_ovf;
  logic [31:0]      in_data, out_sum;
  logic [CNT_W-1:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0]      sum;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } res_t;

  res_t             exp_q[$];
  logic [31:0]      m_acc;
  logic [CNT_W-1:0] m_count;
  logic             m_ovf;

  facc_ieee754 #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [299:0] to_fix(input logic [31:0] f);
    logic [299:0] v;
    if (f[30:23] == 8'd0) return '0;
    v = {276'd0, 1'b1, f[22:0]};
    return v << (f[30:23] - 8'd1);
  endfunction

  // Exact sum in fixed point (lsb = 2^-149), then a single normalise/round step.
  function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [299:0] fa, fb, mag, rest, half_v;
    logic         s, up;
    logic [24:0]  m;
    int           p, e;
    if (a[30:23] == 8'hFF) return {1'b0, a};
    fa = to_fix(a);
    fb = to_fix(b);
    if (a[31] == b[31]) begin
      mag = fa + fb; s = a[31];
    end else if (fa >= fb) begin
      mag = fa - fb; s = a[31];
    end else begin
      mag = fb - fa; s = b[31];
    end
    if (mag == '0) return 33'd0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p < 23) return 33'd0;
    m      = {1'b0, mag[p -: 24]};
    rest   = mag & ((300'd1 << (p - 23)) - 300'd1);
    half_v = (p >= 24) ? (300'd1 << (p - 24)) : '0;
`ifdef FACC_RNE_ROUND_EN
    up = (rest > half_v) || (rest == half_v && rest != '0 && m[0]);
`else
    up = 1'b0;
`endif
    m = m + {24'd0, up};
    e = p - 22;
    if (m[24]) begin
      e++;
      m = m >> 1;
    end
    if (e <= 0) return 33'd0;
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    return {1'b0, s, 8'(e), m[22:0]};
  endfunction

  task automatic model_reset();
    m_acc   = 32'd0;
    m_count = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    logic [32:0] r;
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check("in_ready_wait", in_ready, 1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    r = fp_add(m_acc, d);
    m_acc = r[31:0];
    m_ovf = m_ovf | r[32];
    if (m_count != {CNT_W{1'b1}}) m_count++;
    if (last) begin
      exp_q.push_back({m_acc, m_count, m_ovf});
      model_reset();
    end
  endtask

  always @(negedge clk) begin : mon
    res_t e;
    if (rst_n && out_valid) begin
      check("in_ready_low_in_done", in_ready, 0);
      if (out_ready && !clear) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got sum %h with no sum outstanding", out_sum);
        end else begin
          e = exp_q.pop_front();
          check("out_sum", out_sum, e.sum);
          check("out_count", out_count, e.count);
          check("out_ovf", out_ovf, e.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
    out_ready = 1'b1;
    model_reset();
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf", out_ovf, 0);

    check("pin_1_plus_2", fp_add(32'h3F800000, 32'h40000000), 33'h040400000);
    check("pin_1_minus_1", fp_add(32'h3F800000, 32'hBF800000), 33'h000000000);
    check("pin_denorm", fp_add(32'h3F800000, 32'h00000001), 33'h03F800000);
    check("pin_overflow", fp_add(32'h7F7FFFFF, 32'h7F7FFFFF), 33'h17F800000);
`ifdef FACC_RNE_ROUND_EN
    check("pin_round", fp_add(32'h3F800000, 32'h33C00000), 33'h03F800001);
`else
    check("pin_round", fp_add(32'h3F800000, 32'h33C00000), 33'h03F800000);
`endif
    check("pin_neg", fp_add(32'hC0A00000, 32'h40400000), 33'h0C0000000);

    @(negedge clk);
    rst_n = 1'b1;

    send(32'h3F800000, 1'b0);
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      k++;
      @(negedge clk);
    end
    check("accept_latency", k, 3);
    check("acc_after_term", out_sum, m_acc);
    send(32'h40000000, 1'b1);

    send(32'h3F800000, 1'b0); send(32'hBF800000, 1'b1);
    send(32'h3F800000, 1'b0); send(32'h00000001, 1'b1);
    send(32'h7F7FFFFF, 1'b0); send(32'h7F7FFFFF, 1'b1);
    send(32'h3F800000, 1'b0); send(32'h33C00000, 1'b1);
    send(32'h3FC00000, 1'b0); send(32'h40100000, 1'b1);
    send(32'h3F800000, 1'b0); send(32'h40000000, 1'b0); send(32'h40800000, 1'b1);
    send(32'h40400000, 1'b0); send(32'hC0000000, 1'b1);
    send(32'hC0A00000, 1'b0); send(32'h40400000, 1'b1);
    send(32'h7F7FFFFF, 1'b0); send(32'h7F7FFFFF, 1'b0); send(32'hC0000000, 1'b1);
    send(32'hBF800000, 1'b1);
    send(32'h3F800000, 1'b1);

    // Backpressure: DONE must hold steady while out_ready is low.
    send(32'h3F800000, 1'b0);
    out_ready = 1'b0;
    send(32'h3F800000, 1'b1);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("done_reached", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      if (exp_q.size() != 0) begin
        check("bp_out_sum", out_sum, exp_q[0].sum);
        check("bp_out_count", out_count, exp_q[0].count);
        check("bp_out_ovf", out_ovf, exp_q[0].ovf);
      end
    end
    @(posedge clk);
    #1 out_ready = 1.0;

    // Clear during ALIGN aborts the partial sum.
    send(32'h40800000, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    check("clear_in_ready", in_ready, 0);
    @(posedge clk);
    #1 clear = 1'b0;
    model_reset();
    @(negedge clk);
    check("clear_idle_next", in_ready, 1);
    check("clear_count", out_count, m_count);
    check("clear_sum", out_sum, m_acc);
    send(32'h40000000, 1'b0); send(32'h40400000, 1'b1);

    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("queue_drained_1", exp_q.size(), 0);

    // Reset mid-sum clears every output without waiting for a clock.
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    #2;
    check("pre_rst_count", out_count, m_count);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_sum", out_sum, 0);
    check("mid_rst_out_count", out_count, 0);
    check("mid_rst_out_ovf", out_ovf, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h40400000, 1'b1);

    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("queue_drained_2", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
